// File: rtl/mux8_rr_arbiter.sv
// Purpose : round-robin arbiter steering one of eight requesters through a shared 8:1 single-bit mux.
// Latency : gnt/sel register on the edge that first sees a request; y/y_valid one edge later.
// Backpressure: none; requesters hold req while they want service, and a grant ends after MAX_BURST cycles.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst_n    asynchronous active-low reset
//   en       global arbitration enable
//   req[7:0] request lines, req[k] belongs to requester k
//   din[7:0] mux data inputs, din[k] belongs to requester k
//   gnt[7:0] registered one-hot grant (zero when idle)
//   sel[2:0] registered index of the granted channel
//   busy     high while the arbiter is in GRANT
//   y        registered data bit from the granted channel
//   y_valid  y was sampled in a cycle where the holder still requested
module mux8_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       y,
  output logic       y_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt, sel_nxt;
  logic [7:0]       gnt_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             y_nxt, y_valid_nxt;
  logic [2:0]       win_from_ptr, win_from_sel;
  logic             any_req, release_gnt;

  // First requester found scanning start, start+1, ... with 3-bit wrap.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign any_req      = |req;
  assign win_from_ptr = rr_pick(req, ptr);
  // On release the pointer moves past the holder; this winner is computed
  // with that future pointer so a regrant costs no idle cycle.
  assign win_from_sel = rr_pick(req, sel + 3'd1);
  assign release_gnt  = !en || !req[sel] || (cnt == CNT_W'(MAX_BURST));
  assign busy         = (state == GRANT);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    y_nxt       = y;
    y_valid_nxt = 1'b0;
    if (state == IDLE) begin
      gnt_nxt = 8'h00;
      if (en && any_req) begin
        gnt_nxt   = 8'd1 << win_from_ptr;
        sel_nxt   = win_from_ptr;
        cnt_nxt   = CNT_W'(1);
        state_nxt = GRANT;
      end
    end else begin
      // Sampling happens even on the releasing edge, as long as the holder still requests.
      if (req[sel]) begin
        y_nxt       = din[sel];
        y_valid_nxt = 1'b1;
      end
      if (release_gnt) begin
        ptr_nxt = sel + 3'd1;
        if (en && any_req) begin
          gnt_nxt = 8'd1 << win_from_sel;
          sel_nxt = win_from_sel;
          cnt_nxt = CNT_W'(1);
        end else begin
          gnt_nxt   = 8'h00;
          state_nxt = IDLE;
        end
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 8'h00;
      sel     <= 3'd0;
      ptr     <= 3'd0;
      cnt     <= '0;
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      sel     <= sel_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Purpose : directed checks of the round-robin 8:1 arbiter.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       y;
  logic       y_valid;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .busy(busy), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; req = 8'h00; din = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b1; req = 8'h08; din = 8'h08;
    tick(); tick(); tick();
    checks++;
    if (gnt !== 8'h08 || y !== 1'b1) begin
      errors++; $display("FAIL reset_pre gnt=%h y=%b want gnt=08 y=1", gnt, y);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || y !== 1'b0 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async gnt=%h sel=%0d busy=%b y=%b yv=%b want all 0", gnt, sel, busy, y, y_valid);
    end
    tick();
    rst_n = 1'b1; req = 8'h00;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h00 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle cycle %0d gnt=%h busy=%b want 00 0", c, gnt, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; req = 8'h08; din = 8'h08;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h08 || sel !== 3'd3 || busy !== 1'b1) begin
        errors++; $display("FAIL single_gnt cycle %0d gnt=%h sel=%0d busy=%b want 08 3 1", c, gnt, sel, busy);
      end
      checks++;
      if (c == 1) begin
        if (y_valid !== 1'b0) begin
          errors++; $display("FAIL single_first_yv cycle %0d yv=%b want 0", c, y_valid);
        end
      end else if (y !== 1'b1 || y_valid !== 1'b1) begin
        errors++; $display("FAIL single_y cycle %0d y=%b yv=%b want 1 1", c, y, y_valid);
      end
    end
  endtask

  task automatic test_contention();
    int ch;
    int pch;
    do_reset();
    en = 1'b1; req = 8'hFF; din = 8'hA5;
    for (int k = 1; k <= 36; k++) begin
      tick();
      ch = ((k - 1) / 4) % 8;
      checks++;
      if (gnt !== (8'd1 << ch) || sel !== 3'(ch) || busy !== 1'b1) begin
        errors++; $display("FAIL contention_gnt cycle %0d gnt=%h sel=%0d want ch %0d", k, gnt, sel, ch);
      end
      if (k >= 2) begin
        pch = ((k - 2) / 4) % 8;
        checks++;
        if (y !== din[pch] || y_valid !== 1'b1) begin
          errors++; $display("FAIL contention_y cycle %0d y=%b yv=%b want %b 1", k, y, y_valid, din[pch]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int ch;
    do_reset();
    en = 1'b1; req = 8'h81; din = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      tick();
      ch = (((k - 1) / 4) == 1) ? 7 : 0;
      checks++;
      if (gnt !== (8'd1 << ch) || sel !== 3'(ch)) begin
        errors++; $display("FAIL wrap_gnt cycle %0d gnt=%h sel=%0d want ch %0d", k, gnt, sel, ch);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    en = 1'b1; req = 8'h24; din = 8'h04;
    tick();
    checks++;
    if (gnt !== 8'h04 || sel !== 3'd2) begin
      errors++; $display("FAIL early_first gnt=%h sel=%0d want 04 2", gnt, sel);
    end
    tick();
    checks++;
    if (y !== 1'b1 || y_valid !== 1'b1) begin
      errors++; $display("FAIL early_y2 y=%b yv=%b want 1 1", y, y_valid);
    end
    req = 8'h20;
    tick();
    checks++;
    if (gnt !== 8'h20 || sel !== 3'd5 || busy !== 1'b1 || y_valid !== 1'b0 || y !== 1'b1) begin
      errors++;
      $display("FAIL early_switch gnt=%h sel=%0d busy=%b y=%b yv=%b want 20 5 1 1 0", gnt, sel, busy, y, y_valid);
    end
    tick();
    checks++;
    if (y !== 1'b0 || y_valid !== 1'b1 || gnt !== 8'h20) begin
      errors++; $display("FAIL early_newy y=%b yv=%b gnt=%h want 0 1 20", y, y_valid, gnt);
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b1; req = 8'h12; din = 8'h12;
    tick();
    checks++;
    if (gnt !== 8'h02 || sel !== 3'd1) begin
      errors++; $display("FAIL enable_first gnt=%h sel=%0d want 02 1", gnt, sel);
    end
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0 || y_valid !== 1'b1 || y !== 1'b1) begin
      errors++; $display("FAIL enable_off gnt=%h busy=%b y=%b yv=%b want 00 0 1 1", gnt, busy, y, y_valid);
    end
    tick();
    checks++;
    if (y_valid !== 1'b0 || y !== 1'b1 || sel !== 3'd1 || gnt !== 8'h00) begin
      errors++; $display("FAIL enable_idle y=%b yv=%b sel=%0d gnt=%h want 1 0 1 00", y, y_valid, sel, gnt);
    end
    en = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h10 || sel !== 3'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL enable_resume gnt=%h sel=%0d busy=%b want 10 4 1", gnt, sel, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'h00; din = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_early_release();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
